// File: rtl/user_input_reader.sv
// Memory-mapped input peripheral: synchronised, debounced DIP switches and user keys,
// readable over the bridge, with a level interrupt on any debounced key press.

module uir_sync_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// One debounce group: a single counter shared by all bits, so any toggle restarts the group.
module uir_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] stable_nxt
);
    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        uir_sync_lane u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (raw[i]),
            .q    (sync_q[i])
        );
    end

    // Polarity is applied after the synchroniser, so flops reset to 0 read as the inverted level.
    assign lvl        = (ACTIVE_LOW != 0) ? ~sync_q : sync_q;
    assign stable_nxt = (lvl == cand && cnt == CNT_MAX) ? cand : stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            stable <= stable_nxt;
            if (lvl != cand) begin
                cand <= lvl;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module user_input_reader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_ACTIVE_LOW   = 1,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        we,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    input  logic [63:0] dip_switch,
    input  logic [7:0]  user_key,
    output logic        irq
);
    logic [63:0] sw_stable;
    logic [63:0] sw_nxt;
    logic [7:0]  key_stable;
    logic [7:0]  key_nxt;
    logic        ie;
    logic        pending;
    logic        ctrl_wr;
    logic        press;
    logic        unused_bits;

    uir_debounce #(
        .WIDTH          (64),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (SW_ACTIVE_LOW)
    ) u_sw (
        .clk       (clk),
        .rst_n     (reset),
        .raw       (dip_switch),
        .stable    (sw_stable),
        .stable_nxt(sw_nxt)
    );

    uir_debounce #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (KEY_ACTIVE_LOW)
    ) u_key (
        .clk       (clk),
        .rst_n     (reset),
        .raw       (user_key),
        .stable    (key_stable),
        .stable_nxt(key_nxt)
    );

    assign unused_bits = ^{Din[31:2], sw_nxt};
    assign ctrl_wr     = we && (Addr == 2'd3);
    assign press       = |(key_nxt & ~key_stable);

    // A press on the same edge as a W1C wins, so no event is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie      <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (ctrl_wr)
                ie <= Din[0];
            pending <= press | (pending & ~(ctrl_wr & Din[1]));
        end
    end

    assign irq = pending & ie;

    always_comb begin
        Dout = '0;
        case (Addr)
            2'd0: Dout = sw_stable[31:0];
            2'd1: Dout = sw_stable[63:32];
            2'd2: Dout = {24'b0, key_stable};
            2'd3: Dout = {30'b0, pending, ie};
            default: Dout = '0;
        endcase
    end
endmodule

// File: tb/tb_user_input_reader.sv
// Directed bench for user_input_reader with DEBOUNCE_CYCLES=4 (7-edge input latency).

module tb_user_input_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  Addr = 2'd0;
    logic        we = 1'b0;
    logic [31:0] Din = 32'd0;
    logic [31:0] Dout;
    logic [63:0] dip_switch = 64'hFFFF_FFFF_FFFF_FFFE;
    logic [7:0]  user_key = 8'hFF;
    logic        irq;

    int checks = 0;
    int errors = 0;

    user_input_reader #(
        .DEBOUNCE_CYCLES(4),
        .SW_ACTIVE_LOW  (1),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .we        (we),
        .Din       (Din),
        .Dout      (Dout),
        .dip_switch(dip_switch),
        .user_key  (user_key),
        .irq       (irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        Addr = a;
        #1;
        chk(tag, Dout, exp);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        chk(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we  = 1'b0;
        Din = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset state and switch latency
        #3;
        rd(2'd0, 32'h0, "reset_sw_lo");
        rd(2'd3, 32'h0, "reset_ctrl");
        chk_irq(1'b0, "reset_irq");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(6);
        rd(2'd0, 32'h0, "sw_lo_edge6");
        step(1);
        rd(2'd0, 32'h1, "sw_lo_edge7");
        rd(2'd1, 32'h0, "sw_hi_zero");
        rd(2'd2, 32'h0, "key_idle");
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd0, 32'h1, "sw_lo_write_ignored");
        rd(2'd2, 32'h0, "key_write_ignored");
        Addr = 2'd3; Din = 32'h3; we = 1'b0;
        step(1);
        rd(2'd3, 32'h0, "ctrl_no_we");
        Din = 32'h0;

        // 2: glitch reject, then a held press sets pending with ie=0
        user_key = 8'hF7;
        step(3);
        user_key = 8'hFF;
        step(10);
        rd(2'd2, 32'h0, "glitch_key");
        rd(2'd3, 32'h0, "glitch_ctrl");
        user_key = 8'hF7;
        step(6);
        rd(2'd2, 32'h0, "key3_edge6");
        step(1);
        rd(2'd2, 32'h08, "key3_edge7");
        rd(2'd3, 32'h2, "key3_pending_ie0");
        chk_irq(1'b0, "key3_irq_masked");
        wr(2'd3, 32'h2);
        rd(2'd3, 32'h0, "key3_w1c");
        user_key = 8'hFF;
        step(10);
        rd(2'd2, 32'h0, "key3_released");
        rd(2'd3, 32'h0, "key3_release_no_pend");

        // 3: interrupt flow
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h1, "ie_set");
        chk_irq(1'b0, "ie_set_irq");
        user_key = 8'hFE;
        step(6);
        rd(2'd3, 32'h1, "key0_edge6_ctrl");
        chk_irq(1'b0, "key0_edge6_irq");
        step(1);
        rd(2'd2, 32'h01, "key0_edge7");
        rd(2'd3, 32'h3, "key0_pending");
        chk_irq(1'b1, "key0_irq");
        wr(2'd3, 32'h3);
        rd(2'd3, 32'h1, "key0_w1c");
        chk_irq(1'b0, "key0_w1c_irq");
        user_key = 8'hFF;
        step(10);
        rd(2'd2, 32'h0, "key0_released");
        rd(2'd3, 32'h1, "key0_release_no_pend");
        chk_irq(1'b0, "key0_release_irq");

        // 4: W1C on the same edge as a press
        user_key = 8'hDF;
        step(6);
        rd(2'd3, 32'h1, "key5_edge6_ctrl");
        Addr = 2'd3; Din = 32'h3; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; Din = 32'h0;
        rd(2'd2, 32'h20, "key5_stable");
        rd(2'd3, 32'h3, "set_wins_over_clear");
        chk_irq(1'b1, "set_wins_irq");
        wr(2'd3, 32'h3);
        rd(2'd3, 32'h1, "key5_w1c");
        user_key = 8'hFF;
        step(10);

        // 5: async reset mid-debounce
        user_key = 8'hFD;
        step(7);
        rd(2'd3, 32'h3, "key1_pending");
        chk_irq(1'b1, "key1_irq");
        user_key = 8'hF9;
        step(2);
        Addr = 2'd2;
        #1;
        reset = 1'b0;
        #1;
        chk_irq(1'b0, "async_reset_irq");
        chk("async_reset_key", Dout, 32'h0);
        rd(2'd3, 32'h0, "async_reset_ctrl");
        rd(2'd0, 32'h0, "async_reset_sw");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(6);
        rd(2'd2, 32'h0, "post_reset_edge6");
        step(1);
        rd(2'd2, 32'h06, "post_reset_edge7");
        rd(2'd3, 32'h2, "post_reset_pending_ie0");
        chk_irq(1'b0, "post_reset_irq_masked");
        wr(2'd3, 32'h1);
        chk_irq(1'b1, "ie_enable_raises_irq");
        wr(2'd3, 32'h3);
        rd(2'd3, 32'h1, "post_reset_w1c");
        user_key = 8'hFF;
        step(10);
        rd(2'd0, 32'h1, "sw_lo_after_reset");

        // 6: bounce on dip_switch[40] restarts the switch group
        for (int i = 0; i < 10; i++) begin
            dip_switch[40] = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        rd(2'd1, 32'h0, "bounce_hi_zero");
        dip_switch[40] = 1'b0;
        step(6);
        rd(2'd1, 32'h0, "bounce_edge6");
        step(1);
        rd(2'd1, 32'h0000_0100, "bounce_edge7");
        rd(2'd0, 32'h1, "bounce_lo_kept");
        rd(2'd3, 32'h1, "final_ctrl");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
